// File: rtl/reduce_sequencer.sv
// Reduce-step sequencer: pops an operator and one or two operands, runs the ALU, pushes the result.
// Optional macro REDUCE_TIMEOUT_EN adds a 16-cycle ALU timeout that ends the step with error code 11.
module reduce_sequencer #(
    parameter int DW = 32,
    parameter int OW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_err_code,
    input  logic [OW-1:0] i_op_top,
    input  logic          i_op_empty,
    output logic          o_op_pop,
    input  logic [DW-1:0] i_dt_top,
    input  logic          i_dt_empty,
    output logic          o_dt_pop,
    output logic          o_dt_push,
    output logic [DW-1:0] o_dt_wdata,
    output logic [DW-1:0] o_al_A,
    output logic [DW-1:0] o_al_B,
    output logic [OW-1:0] o_al_op,
    output logic          o_al_go,
    input  logic          i_al_done,
    input  logic [DW-1:0] i_al_C
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP_OP, S_POP_B, S_POP_A, S_EXEC, S_WAIT, S_PUSH, S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_setErr;
    logic [1:0]    w_errCode;
    logic          r_err;
    logic [1:0]    r_errCode;
    logic [OW-1:0] r_alOp;
    logic [DW-1:0] r_alA;
    logic [DW-1:0] r_alB;
    logic [DW-1:0] r_result;
`ifdef REDUCE_TIMEOUT_EN
    logic [3:0]    r_tmoCount;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_setErr    = 1'b0;
        w_errCode   = 2'b00;
        o_busy      = (r_state != S_IDLE);
        o_done      = 1'b0;
        o_op_pop    = 1'b0;
        o_dt_pop    = 1'b0;
        o_dt_push   = 1'b0;
        o_al_go     = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_nextState = S_POP_OP;
            S_POP_OP: begin
                if (i_op_empty) begin
                    w_nextState = S_FIN;
                    w_setErr    = 1'b1;
                    w_errCode   = 2'b01;
                end else begin
                    o_op_pop    = 1'b1;
                    w_nextState = S_POP_B;
                end
            end
            S_POP_B: begin
                if (i_dt_empty) begin
                    w_nextState = S_FIN;
                    w_setErr    = 1'b1;
                    w_errCode   = 2'b10;
                end else begin
                    o_dt_pop    = 1'b1;
                    w_nextState = r_alOp[OW-1] ? S_EXEC : S_POP_A;
                end
            end
            S_POP_A: begin
                if (i_dt_empty) begin
                    w_nextState = S_FIN;
                    w_setErr    = 1'b1;
                    w_errCode   = 2'b10;
                end else begin
                    o_dt_pop    = 1'b1;
                    w_nextState = S_EXEC;
                end
            end
            S_EXEC: begin
                o_al_go     = 1'b1;
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (i_al_done) begin
                    w_nextState = S_PUSH;
                end
`ifdef REDUCE_TIMEOUT_EN
                else if (r_tmoCount == 4'hF) begin
                    w_nextState = S_FIN;
                    w_setErr    = 1'b1;
                    w_errCode   = 2'b11;
                end
`endif
            end
            S_PUSH: begin
                o_dt_push   = 1'b1;
                w_nextState = S_FIN;
            end
            S_FIN: begin
                o_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operand, operator, result and error registers; errors never touch the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err     <= 1'b0;
            r_errCode <= 2'b00;
            r_alOp    <= '0;
            r_alA     <= '0;
            r_alB     <= '0;
            r_result  <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_err     <= 1'b0;
                r_errCode <= 2'b00;
            end
            if (w_setErr) begin
                r_err     <= 1'b1;
                r_errCode <= w_errCode;
            end
            if (r_state == S_POP_OP && !i_op_empty) r_alOp <= i_op_top;
            if (r_state == S_POP_B && !i_dt_empty) begin
                r_alB <= i_dt_top;
                if (r_alOp[OW-1]) r_alA <= '0;
            end
            if (r_state == S_POP_A && !i_dt_empty) r_alA <= i_dt_top;
            if (r_state == S_WAIT && i_al_done) r_result <= i_al_C;
        end
    end

`ifdef REDUCE_TIMEOUT_EN
    // EXEC always precedes WAIT, so clearing there zeroes the count on WAIT entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_tmoCount <= 4'h0;
        else if (r_state == S_EXEC)   r_tmoCount <= 4'h0;
        else if (r_state == S_WAIT)   r_tmoCount <= r_tmoCount + 4'h1;
    end
`endif

    assign o_err      = r_err;
    assign o_err_code = r_errCode;
    assign o_al_op    = r_alOp;
    assign o_al_A     = r_alA;
    assign o_al_B     = r_alB;
    assign o_dt_wdata = r_result;

endmodule
